lsu_mem_master: RTL and testbench

Initiator side of the data-memory bus. It accepts load/store requests from the CPU pipeline over a valid/ready handshake and drives the word-wide data memory's `mem_access_addr`, `mem_write_data`, `mem_write_en` and `mem_read` signals. The memory's `mem_read_data` is combinational and its writes take effect on posedge clk. Byte and halfword stores are done as read-modify-write. Load data is lane-extracted and sign- or zero-extended before it is returned to the pipeline.

---
 rtl/lsu_pkg.sv | 62 ++++++
 rtl/lsu_mem_master_lane_align.sv | 19 +
 rtl/lsu_mem_master.sv | 163 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store data-memory master.
// Latency: none, types and pure functions only.
// Backpressure: not applicable.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Little-endian lane select and extension; size 2'b11 behaves as a word.
   function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                input logic [1:0]  addr_lo,
                                                input logic [1:0]  size,
                                                input logic        is_unsigned);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{addr_lo, 3'b000} +: 8];
      h = word[{addr_lo[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: r = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
         SZ_HALF: r = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace the addressed lane of word with the right-aligned store data.
   function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  addr_lo,
                                              input logic [1:0]  size);
      logic [31:0] r;
      r = word;
      case (size)
         SZ_BYTE: r[{addr_lo, 3'b000} +: 8]    = wdata[7:0];
         SZ_HALF: r[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
         default: r = wdata;
      endcase
      return r;
   endfunction

   // Half on an odd byte, or word not on a 4-byte boundary.
   function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                          input logic [1:0] size);
      logic r;
      case (size)
         SZ_BYTE: r = 1'b0;
         SZ_HALF: r = addr_lo[0];
         default: r = |addr_lo;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Combinational lane extract (loads) and lane merge (read-modify-write stores).
// Latency: 0 cycles, purely combinational.
// Backpressure: none, outputs follow inputs.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_rdata,
   output logic [31:0] o_merged
);

   assign o_rdata  = lane_extract(i_word, i_addr_lo, i_size, i_unsigned);
   assign o_merged = lane_merge(i_word, i_wdata, i_addr_lo, i_size);

endmodule

// File: rtl/lsu_mem_master.sv
// Data-memory initiator: one load/store at a time, sub-word stores by read-modify-write.
// Latency: load 2, word store 2, byte/half store 3, trapped misaligned 1 cycle(s).
// Backpressure: req_ready only in IDLE; rsp_valid is a single pulse with no backpressure.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests skip memory and respond with rsp_err.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data
);

   state_t            r_state;
   logic              r_req_ready;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [1:0]        r_addr_lo;
   logic [DATA_W-1:0] r_wdata;
   logic              r_mem_read;
   logic              r_mem_write_en;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;

   logic              w_accept;
   logic [ADDR_W-1:0] w_word_addr;
   logic [DATA_W-1:0] w_extract;
   logic [DATA_W-1:0] w_merged;

   assign w_accept    = req_valid & r_req_ready;
   assign w_word_addr = {req_addr[ADDR_W-1:2], 2'b00};

   // One aligner serves both the load return path and the store merge path.
   lsu_lane_align u_align (
      .i_word     (mem_read_data),
      .i_wdata    (r_wdata),
      .i_addr_lo  (r_addr_lo),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_rdata    (w_extract),
      .o_merged   (w_merged)
   );

`ifdef LSU_MISALIGN_TRAP_EN
   logic r_rsp_err;
   logic w_misaligned;
   assign w_misaligned = is_misaligned(req_addr[1:0], req_size);
   assign rsp_err      = r_rsp_err;
`else
   assign rsp_err      = 1'b0;
`endif

   // Request FSM; every bus/response output is a register so strobes are glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_req_ready    <= 1'b1;
         r_we           <= 1'b0;
         r_size         <= SZ_BYTE;
         r_unsigned     <= 1'b0;
         r_addr_lo      <= 2'b00;
         r_wdata        <= '0;
         r_mem_read     <= 1'b0;
         r_mem_write_en <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
         r_rsp_valid    <= 1'b0;
         r_rsp_rdata    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         r_rsp_err      <= 1'b0;
`endif
      end else begin
         // Strobes and response fields default low; states below re-assert them.
         r_mem_read     <= 1'b0;
         r_mem_write_en <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
         r_rsp_valid    <= 1'b0;
         r_rsp_rdata    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         r_rsp_err      <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_req_ready <= 1'b0;
                  r_we        <= req_we;
                  r_size      <= req_size;
                  r_unsigned  <= req_unsigned;
                  r_addr_lo   <= req_addr[1:0];
                  r_wdata     <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                  if (w_misaligned) begin
                     r_state     <= ST_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                  end else
`endif
                  if (req_we && req_size[1]) begin
                     // Full-word store needs no read: write directly.
                     r_state        <= ST_WRITE;
                     r_mem_write_en <= 1'b1;
                     r_mem_addr     <= w_word_addr;
                     r_mem_wdata    <= req_wdata;
                  end else begin
                     r_state    <= ST_READ;
                     r_mem_read <= 1'b1;
                     r_mem_addr <= w_word_addr;
                  end
               end
            end
            ST_READ: begin
               if (r_we) begin
                  r_state        <= ST_WRITE;
                  r_mem_write_en <= 1'b1;
                  r_mem_addr     <= r_mem_addr;
                  r_mem_wdata    <= w_merged;
               end else begin
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= w_extract;
               end
            end
            ST_WRITE: begin
               r_state     <= ST_RESP;
               r_rsp_valid <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready       = r_req_ready;
   assign rsp_valid       = r_rsp_valid;
   assign rsp_rdata       = r_rsp_rdata;
   assign mem_access_addr = r_mem_addr;
   assign mem_write_data  = r_mem_wdata;
   assign mem_write_en    = r_mem_write_en;
   assign mem_read        = r_mem_read;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a word-wide combinational-read memory model.
// Latency counted as cycles starting with the accept cycle (rsp in Nth cycle => N).
// Expectations adapt to LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_lsu_mem_master;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_access_addr;
   logic [31:0] mem_write_data;
   logic        mem_write_en;
   logic        mem_read;
   logic [31:0] mem_read_data;

   logic [31:0] mem [0:255];
   logic        ld_en;
   logic [7:0]  ld_idx;
   logic [31:0] ld_val;

   int          n_checks;
   int          n_fail;

   int          lat;
   logic [31:0] t_rdata;
   logic        t_err;
   int          rd_cnt;
   int          wr_cnt;
   logic [31:0] rd_addr;
   logic [31:0] wr_addr;
   logic [31:0] wr_dat;
   int          ovl;
   int          rdy_busy;
   logic        post_rsp;
   logic        post_rdy;

   lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_we          (req_we),
      .req_size        (req_size),
      .req_unsigned    (req_unsigned),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_rdata       (rsp_rdata),
      .rsp_err         (rsp_err),
      .mem_access_addr (mem_access_addr),
      .mem_write_data  (mem_write_data),
      .mem_write_en    (mem_write_en),
      .mem_read        (mem_read),
      .mem_read_data   (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_access_addr[9:2]];

   always @(posedge clk) begin
      if (mem_write_en) mem[mem_access_addr[9:2]] <= mem_write_data;
      else if (ld_en)   mem[ld_idx] <= ld_val;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
      end
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] val);
      @(negedge clk);
      ld_en = 1'b1; ld_idx = idx; ld_val = val;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // Issue one request and watch it to completion, sampling 1 time unit after each edge.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
      int  n;
      bit  found;
      @(negedge clk);
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0; t_rdata = '0; t_err = 1'b0; rd_cnt = 0; wr_cnt = 0;
      rd_addr = '0; wr_addr = '0; wr_dat = '0; ovl = 0; rdy_busy = 0;
      found = 1'b0;
      for (int c = 1; c <= 8 && !found; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         if (mem_read)                 begin rd_cnt++; rd_addr = mem_access_addr; end
         if (mem_write_en)             begin wr_cnt++; wr_addr = mem_access_addr; wr_dat = mem_write_data; end
         if (mem_read && mem_write_en) ovl++;
         if (req_ready)                rdy_busy++;
         if (rsp_valid) begin
            found = 1'b1; lat = c; t_rdata = rsp_rdata; t_err = rsp_err;
         end
      end
      if (!found) check("rsp_timeout", 32'(found), 32'd1);
      @(posedge clk); #1;
      post_rsp = rsp_valid;
      post_rdy = req_ready;
   endtask

   initial begin
      int rsp_n, rdy_n, rd_n, bad, b_ovl, wr_n;
      n_checks = 0; n_fail = 0;
      ld_en = 1'b0; ld_idx = '0; ld_val = '0;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      rst_n = 1'b0;

      // Reset values
      #12;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_mem_read",  32'(mem_read), 32'd0);
      check("rst_mem_we",    32'(mem_write_en), 32'd0);
      check("rst_mem_addr",  mem_access_addr, 32'h0);
      check("rst_mem_wdata", mem_write_data, 32'h0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_err",   32'(rsp_err), 32'd0);
      preload(8'h10, 32'h8899AABB);
      @(negedge clk);
      rst_n = 1'b1;

      // Load byte signed 0x43
      do_req(1'b0, 2'b00, 1'b0, 32'h43, 32'h0);
      check("lb_rdata",   t_rdata, 32'hFFFFFF88);
      check("lb_lat",     32'(lat), 32'd2);
      check("lb_rd_cnt",  32'(rd_cnt), 32'd1);
      check("lb_rd_addr", rd_addr, 32'h40);
      check("lb_wr_cnt",  32'(wr_cnt), 32'd0);
      check("lb_rdy_busy", 32'(rdy_busy), 32'd0);
      check("lb_post_rsp", 32'(post_rsp), 32'd0);
      check("lb_post_rdy", 32'(post_rdy), 32'd1);

      // Halfword/word/other lanes
      do_req(1'b0, 2'b01, 1'b1, 32'h40, 32'h0);
      check("lhu_rdata", t_rdata, 32'h0000AABB);
      do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
      check("lw_rdata", t_rdata, 32'h8899AABB);
      check("lw_lat",   32'(lat), 32'd2);
      do_req(1'b0, 2'b01, 1'b0, 32'h42, 32'h0);
      check("lh_hi_rdata", t_rdata, 32'hFFFF8899);
      do_req(1'b0, 2'b00, 1'b1, 32'h42, 32'h0);
      check("lbu_rdata", t_rdata, 32'h00000099);
      do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
      check("lsz3_rdata", t_rdata, 32'h8899AABB);

      // Misaligned word load at 0x42
      do_req(1'b0, 2'b10, 1'b0, 32'h42, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("mis_lat",    32'(lat), 32'd1);
      check("mis_err",    32'(t_err), 32'd1);
      check("mis_rdata",  t_rdata, 32'h0);
      check("mis_rd_cnt", 32'(rd_cnt), 32'd0);
      check("mis_wr_cnt", 32'(wr_cnt), 32'd0);
`else
      check("mis_lat",     32'(lat), 32'd2);
      check("mis_err",     32'(t_err), 32'd0);
      check("mis_rdata",   t_rdata, 32'h8899AABB);
      check("mis_rd_addr", rd_addr, 32'h40);
`endif
      check("mis_post_rdy", 32'(post_rdy), 32'd1);

      // Byte store 0x5A to 0x41 (upper wdata bits must be ignored)
      do_req(1'b1, 2'b00, 1'b0, 32'h41, 32'hFFFFFF5A);
      check("sb_wdata",   wr_dat, 32'h88995ABB);
      check("sb_wr_addr", wr_addr, 32'h40);
      check("sb_lat",     32'(lat), 32'd3);
      check("sb_rd_cnt",  32'(rd_cnt), 32'd1);
      check("sb_wr_cnt",  32'(wr_cnt), 32'd1);
      check("sb_rdata",   t_rdata, 32'h0);
      check("sb_ovl",     32'(ovl), 32'd0);
      check("sb_mem",     mem[8'h10], 32'h88995ABB);

      // Half store to upper half of 0x40
      do_req(1'b1, 2'b01, 1'b0, 32'h42, 32'hABCD1234);
      check("sh_wdata", wr_dat, 32'h12345ABB);
      check("sh_lat",   32'(lat), 32'd3);
      check("sh_mem",   mem[8'h10], 32'h12345ABB);

      // Word store at 0x80
      do_req(1'b1, 2'b10, 1'b0, 32'h80, 32'hDEADBEEF);
      check("sw_rd_cnt",  32'(rd_cnt), 32'd0);
      check("sw_wr_cnt",  32'(wr_cnt), 32'd1);
      check("sw_wr_addr", wr_addr, 32'h80);
      check("sw_wdata",   wr_dat, 32'hDEADBEEF);
      check("sw_lat",     32'(lat), 32'd2);
      check("sw_rdata",   t_rdata, 32'h0);
      check("sw_mem",     mem[8'h20], 32'hDEADBEEF);

      // Back-to-back: req_valid held high across two loads
      @(negedge clk);
      req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h80; req_wdata = '0;
      req_valid = 1'b1;
      rsp_n = 0; rdy_n = 0; rd_n = 0; bad = 0; b_ovl = 0; wr_n = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin
            rsp_n++;
            check("b2b_rdata", rsp_rdata, 32'hDEADBEEF);
         end
         if (req_ready) rdy_n++;
         if (mem_read) rd_n++;
         if (mem_write_en) wr_n++;
         if (mem_read && mem_write_en) b_ovl++;
         if (req_ready && (mem_read || rsp_valid)) bad++;
      end
      req_valid = 1'b0;
      check("b2b_rsp_n", 32'(rsp_n), 32'd2);
      check("b2b_rdy_n", 32'(rdy_n), 32'd2);
      check("b2b_rd_n",  32'(rd_n), 32'd2);
      check("b2b_wr_n",  32'(wr_n), 32'd0);
      check("b2b_ovl",   32'(b_ovl), 32'd0);
      check("b2b_busy_rdy", 32'(bad), 32'd0);
      repeat (2) @(posedge clk);

      // Reset pulsed during READ of a byte store
      @(negedge clk);
      req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'h77;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("mid_in_read", 32'(mem_read), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_rdy",   32'(req_ready), 32'd1);
      check("mid_rst_rd",    32'(mem_read), 32'd0);
      check("mid_rst_addr",  mem_access_addr, 32'h0);
      check("mid_rst_rsp",   32'(rsp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wr_n = 0; rsp_n = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (mem_write_en) wr_n++;
         if (rsp_valid) rsp_n++;
      end
      check("mid_no_write", 32'(wr_n), 32'd0);
      check("mid_no_rsp",   32'(rsp_n), 32'd0);
      check("mid_rdy",      32'(req_ready), 32'd1);
      check("mid_mem",      mem[8'h10], 32'h12345ABB);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
